// File: rtl/im_boot_loader.sv
// im_boot_loader: streams a program image into instruction memory, then
// releases the CPU from reset. In RUN it becomes a transparent mux between
// the CPU and the IM RAM write/address port.
module im_boot_loader #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int IM_DEPTH = 2048,
  parameter int HOLD_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_s_valid,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_last,
  output logic              o_s_ready,
  input  logic [ADDR_W-1:0] i_cpu_pc,
  input  logic              i_cpu_im_w_en,
  input  logic [DATA_W-1:0] i_cpu_im_w_data,
  output logic              o_im_w_en,
  output logic [ADDR_W-1:0] o_im_address,
  output logic [DATA_W-1:0] o_im_w_data,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic              o_overflow_err,
  output logic [ADDR_W:0]   o_word_count
);

  // Counter wide enough to hold 0..HOLD_CYC-1 (HOLD_CYC must be >= 1).
  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic [HCW-1:0]    r_hold_cnt;
  logic              r_cpu_rst;
  logic              r_load_done;
  logic              r_overflow_err;

  logic w_run;
  logic w_accept;
  logic w_at_end;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = (r_state == S_LOAD) && i_s_valid;
  assign w_at_end = (r_wr_ptr == ADDR_W'(IM_DEPTH - 1));

  // Load sequencing: IDLE -> LOAD -> HOLD -> RUN, with ERR on overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_word_count   <= '0;
      r_hold_cnt     <= '0;
      r_cpu_rst      <= 1'b1;
      r_load_done    <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state      <= S_LOAD;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_word_count <= r_word_count + 1'b1;
            // s_last wins over overflow: a full-depth image ending in s_last is legal.
            if (i_s_last) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end else if (w_at_end) begin
              r_state        <= S_ERR;
              r_overflow_err <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HCW'(HOLD_CYC - 1)) begin
            r_state     <= S_RUN;
            r_load_done <= 1'b1;
            r_hold_cnt  <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        // cpu_rst drops one edge after entering RUN, giving HOLD_CYC+1 edges
        // between the last accepted beat and reset release.
        S_RUN:   r_cpu_rst <= 1'b0;
        S_ERR:   r_cpu_rst <= 1'b1;
        default: r_state   <= S_IDLE;
      endcase
    end
  end

  assign o_s_ready      = (r_state == S_LOAD);
  assign o_im_w_en      = w_run ? i_cpu_im_w_en : w_accept;
  assign o_im_address   = w_run ? i_cpu_pc      : r_wr_ptr;
  assign o_im_w_data    = w_run ? i_cpu_im_w_data : (w_accept ? i_s_data : '0);
  assign o_cpu_rst      = r_cpu_rst;
  assign o_load_done    = r_load_done;
  assign o_overflow_err = r_overflow_err;
  assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_im_boot_loader.sv
// tb_im_boot_loader: drives host-stream loads against a behavioural IM model
// and checks write placement, release timing, overflow and RUN pass-through.
module tb_im_boot_loader;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_last, cpu_w_en;
  logic [DW-1:0] s_data, cpu_w_data;
  logic [AW-1:0] cpu_pc;
  logic          s_ready, im_w_en, cpu_rst, load_done, overflow_err;
  logic [AW-1:0] im_address;
  logic [DW-1:0] im_w_data;
  logic [AW:0]   word_count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] img [$];

  im_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .IM_DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_s_valid(s_valid), .i_s_data(s_data), .i_s_last(s_last), .o_s_ready(s_ready),
    .i_cpu_pc(cpu_pc), .i_cpu_im_w_en(cpu_w_en), .i_cpu_im_w_data(cpu_w_data),
    .o_im_w_en(im_w_en), .o_im_address(im_address), .o_im_w_data(im_w_data),
    .o_cpu_rst(cpu_rst), .o_load_done(load_done), .o_overflow_err(overflow_err),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  // IM RAM model: synchronous write on the rising edge.
  always @(posedge clk) if (im_w_en) ram[im_address] <= im_w_data;

  task automatic apply_reset(input int cyc);
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    cpu_pc = '0; cpu_w_en = 1'b0; cpu_w_data = '0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // Streams img; mode 0 = no bubbles, 1 = bubble before every word after the
  // first, 2 = 0..2 random bubbles. Leaves time at the negedge after the last accept.
  task automatic load_image(input int mode, input bit with_last);
    int ptr = 0;
    int nb;
    start = 1'b1;
    #1 checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", s_ready); end
    @(negedge clk); start = 1'b0;
    #1 checks++; if (word_count !== '0) begin errors++; $display("FAIL start_wc got=%0d exp=0", word_count); end
    for (int i = 0; i < img.size(); i++) begin
      nb = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? $urandom_range(0, 2) : 0;
      for (int b = 0; b < nb; b++) begin
        s_valid = 1'b0; s_data = $urandom; s_last = 1'($urandom);
        #1 checks++;
        if (im_w_en !== 1'b0 || im_address !== AW'(ptr)) begin
          errors++; $display("FAIL bubble w_en=%b addr=%0d exp w_en=0 addr=%0d", im_w_en, im_address, ptr);
        end
        @(negedge clk);
      end
      s_valid = 1'b1; s_data = img[i]; s_last = with_last && (i == img.size() - 1);
      #1 checks++;
      if (im_w_en !== 1'b1 || im_address !== AW'(ptr) || im_w_data !== img[i] ||
          s_ready !== 1'b1 || word_count !== (AW+1)'(ptr) || overflow_err !== 1'b0) begin
        errors++;
        $display("FAIL beat%0d w_en=%b addr=%0d data=%h rdy=%b wc=%0d ovf=%b exp addr=%0d data=%h wc=%0d",
                 i, im_w_en, im_address, im_w_data, s_ready, word_count, overflow_err, ptr, img[i], ptr);
      end
      @(negedge clk);
      ptr++;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Called at the first negedge after the last accept; cpu_rst must fall on
  // the (HOLD+1)th edge after that accept.
  task automatic check_release(input int n);
    for (int k = 1; k <= HOLD + 2; k++) begin
      #1 checks++;
      if (k <= HOLD + 1) begin
        if (cpu_rst !== 1'b1 || s_ready !== 1'b0 || im_w_en !== 1'b0 || load_done !== (k > HOLD)) begin
          errors++; $display("FAIL hold k=%0d cpu_rst=%b rdy=%b w_en=%b done=%b", k, cpu_rst, s_ready, im_w_en, load_done);
        end
      end else begin
        if (cpu_rst !== 1'b0 || load_done !== 1'b1) begin
          errors++; $display("FAIL release cpu_rst=%b done=%b exp 0/1", cpu_rst, load_done);
        end
      end
      @(negedge clk);
    end
    checks++; if (word_count !== (AW+1)'(n)) begin errors++; $display("FAIL word_count got=%0d exp=%0d", word_count, n); end
    for (int j = 0; j < n; j++) begin
      checks++; if (ram[j] !== img[j]) begin errors++; $display("FAIL im[%0d] got=%h exp=%h", j, ram[j], img[j]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    cpu_pc = '0; cpu_w_en = 1'b0; cpu_w_data = '0;
    repeat (3) @(negedge clk);
    #1 checks++;
    if (cpu_rst !== 1'b1 || s_ready !== 1'b0 || im_w_en !== 1'b0 || load_done !== 1'b0 ||
        word_count !== '0 || overflow_err !== 1'b0 || im_address !== '0 || im_w_data !== '0) begin
      errors++; $display("FAIL reset cpu_rst=%b rdy=%b w_en=%b done=%b wc=%0d ovf=%b addr=%0d data=%h",
                         cpu_rst, s_ready, im_w_en, load_done, word_count, overflow_err, im_address, im_w_data);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset(2);
    img = '{32'h00000013, 32'h00100093, 32'h00208113, 32'hFFF00193};
    load_image(0, 1'b1);
    check_release(4);
  endtask

  task automatic test_alternate();
    apply_reset(2);
    img = '{32'h00000013, 32'h00100093, 32'h00208113, 32'hFFF00193};
    load_image(1, 1'b1);
    check_release(4);
  endtask

  task automatic test_random_loads();
    int n;
    for (int r = 0; r < 4; r++) begin
      apply_reset(1);
      n = (r == 0) ? DEPTH : $urandom_range(1, DEPTH);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      load_image(2, 1'b1);
      check_release(n);
    end
  endtask

  task automatic test_overflow();
    apply_reset(2);
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    load_image(2, 1'b0);
    #1 checks++;
    if (overflow_err !== 1'b1 || s_ready !== 1'b0 || cpu_rst !== 1'b1 || ram[DEPTH-1] !== img[DEPTH-1] ||
        word_count !== (AW+1)'(DEPTH)) begin
      errors++; $display("FAIL overflow ovf=%b rdy=%b cpu_rst=%b im_last=%h exp=%h wc=%0d",
                         overflow_err, s_ready, cpu_rst, ram[DEPTH-1], img[DEPTH-1], word_count);
    end
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      s_valid = 1'b1; s_data = $urandom; start = 1'b1; cpu_w_en = 1'b1;
      #1 checks++;
      if (im_w_en !== 1'b0 || s_ready !== 1'b0 || cpu_rst !== 1'b1 || overflow_err !== 1'b1 || load_done !== 1'b0) begin
        errors++; $display("FAIL err_sticky w_en=%b rdy=%b cpu_rst=%b ovf=%b done=%b", im_w_en, s_ready, cpu_rst, overflow_err, load_done);
      end
      @(negedge clk);
    end
    s_valid = 1'b0; start = 1'b0; cpu_w_en = 1'b0;
  endtask

  task automatic test_run_passthrough();
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
    logic          we;
    apply_reset(2);
    img = '{32'h00000013, 32'h00100093, 32'h00208113, 32'hFFF00193};
    load_image(0, 1'b1);
    check_release(4);
    cpu_pc = AW'(5); s_valid = 1'b1; s_last = 1'b1; s_data = 32'h12345678; start = 1'b1;
    #1 checks++;
    if (im_address !== AW'(5) || im_w_en !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL run_pc addr=%0d w_en=%b rdy=%b exp 5/0/0", im_address, im_w_en, s_ready);
    end
    @(negedge clk);
    start = 1'b0; cpu_w_en = 1'b1; cpu_w_data = 32'hDEADBEEF;
    #1 checks++;
    if (im_w_en !== 1'b1 || im_w_data !== 32'hDEADBEEF || im_address !== AW'(5)) begin
      errors++; $display("FAIL run_wr w_en=%b data=%h addr=%0d", im_w_en, im_w_data, im_address);
    end
    @(negedge clk);
    cpu_w_en = 1'b0;
    #1 checks++;
    if (ram[5] !== 32'hDEADBEEF || load_done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++; $display("FAIL run_ram im5=%h done=%b cpu_rst=%b exp deadbeef/1/0", ram[5], load_done, cpu_rst);
    end
    for (int j = 0; j < 4; j++) begin
      checks++; if (ram[j] !== img[j]) begin errors++; $display("FAIL run_keep im[%0d] got=%h exp=%h", j, ram[j], img[j]); end
    end
    for (int t = 0; t < 6; t++) begin
      pc = AW'($urandom_range(8, 4095)); d = $urandom; we = 1'($urandom);
      cpu_pc = pc; cpu_w_data = d; cpu_w_en = we;
      #1 checks++;
      if (im_address !== pc || im_w_en !== we || (we && im_w_data !== d)) begin
        errors++; $display("FAIL run_mux addr=%0d w_en=%b data=%h exp %0d/%b/%h", im_address, im_w_en, im_w_data, pc, we, d);
      end
      @(negedge clk);
      if (we) begin
        checks++; if (ram[pc] !== d) begin errors++; $display("FAIL run_mux_ram im[%0d] got=%h exp=%h", pc, ram[pc], d); end
      end
    end
    cpu_w_en = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset_midload();
    apply_reset(2);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_last = 1'b0; s_data = $urandom; @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1 checks++;
    if (word_count !== '0 || s_ready !== 1'b0 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL midload_rst wc=%0d rdy=%b cpu_rst=%b done=%b", word_count, s_ready, cpu_rst, load_done);
    end
    @(negedge clk); rst = 1'b0;
    img = '{$urandom, $urandom, $urandom};
    load_image(0, 1'b1);
    check_release(3);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_random_loads();
    test_overflow();
    test_run_passthrough();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
